// File: rtl/fc_pkg.sv
// Shared types and sizing helpers for the streaming fully-connected layer.
package fc_pkg;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    BIAS  = 2'd2,
    EMIT  = 2'd3
  } fc_state_e;

  // Accumulator width that cannot overflow for n_inputs full-scale products.
  function automatic int acc_width(input int in_w, input int w_w, input int n_inputs);
    return in_w + w_w + $clog2(n_inputs);
  endfunction

endpackage

// File: rtl/fxp_requant.sv
// Fixed-point requantiser: optional ReLU, optional round-half-up, arithmetic
// right shift to the output fraction, then saturation to the output width.
module fxp_requant #(
  parameter int IN_W     = 28,
  parameter int IN_FRAC  = 21,
  parameter int OUT_W    = 9,
  parameter int OUT_FRAC = 7,
  parameter int ACT      = 1,
  parameter int ROUND    = 1
) (
  input  logic signed [IN_W-1:0]  val_i,
  output logic signed [OUT_W-1:0] val_o
);

  localparam int SH      = IN_FRAC - OUT_FRAC;
  localparam int HALF_SH = (SH > 0) ? SH - 1 : 0;
  localparam logic signed [IN_W:0] HALF  = (ROUND != 0 && SH > 0) ?
                                           ((IN_W+1)'(1) << HALF_SH) : '0;
  localparam logic signed [IN_W:0] MAX_S = (IN_W+1)'((1 << (OUT_W-1)) - 1);
  localparam logic signed [IN_W:0] MIN_S = -MAX_S - (IN_W+1)'(1);

  // One guard bit keeps the rounding add from wrapping at full scale.
  logic signed [IN_W:0] relu_s;
  logic signed [IN_W:0] rnd_s;
  logic signed [IN_W:0] shf_s;

  // ReLU, round, shift and clamp.
  always_comb begin
    relu_s = {val_i[IN_W-1], val_i};
    if (ACT != 0 && val_i[IN_W-1]) begin
      relu_s = '0;
    end else begin
      relu_s = {val_i[IN_W-1], val_i};
    end
    rnd_s = relu_s + HALF;
    shf_s = rnd_s >>> SH;
    if (shf_s > MAX_S) begin
      val_o = MAX_S[OUT_W-1:0];
    end else if (shf_s < MIN_S) begin
      val_o = MIN_S[OUT_W-1:0];
    end else begin
      val_o = shf_s[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/fc_layer_stream.sv
// Streaming fully-connected layer: one input sample per cycle is multiplied by a
// weight row and accumulated into all neurons, then biased results are emitted.
module fc_layer_stream
  import fc_pkg::*;
#(
  parameter int INPUT_NUM   = 784,
  parameter int NODE_NUM    = 128,
  parameter int IN_WIDTH    = 17,
  parameter int IN_FRACTION = 14,
  parameter int W_WIDTH     = 9,
  parameter int W_FRACTION  = 7,
  parameter int OUT_WIDTH   = 9,
  parameter int OUT_FRACTION = 7,
  parameter int ACT         = 1,
  parameter int ROUND       = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic signed [IN_WIDTH-1:0]          in_data,
  output logic [$clog2(INPUT_NUM)-1:0]        w_addr,
  input  logic [NODE_NUM*W_WIDTH-1:0]         w_data,
  input  logic [NODE_NUM*W_WIDTH-1:0]         bias_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic signed [OUT_WIDTH-1:0]         out_data,
  output logic [$clog2(NODE_NUM)-1:0]         out_idx,
  output logic                                out_last
);

  localparam int ACC_W = acc_width(IN_WIDTH, W_WIDTH, INPUT_NUM);
  localparam int PW    = IN_WIDTH + W_WIDTH;
  localparam int CW    = $clog2(INPUT_NUM);
  localparam int IW    = $clog2(NODE_NUM);
  localparam logic [CW-1:0] K_LAST = CW'(INPUT_NUM - 1);
  localparam logic [IW-1:0] N_LAST = IW'(NODE_NUM - 1);

  fc_state_e                   state_q, state_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic signed [IN_WIDTH-1:0]  x_q, x_d;
  logic                        pv_q, pv_d;
  logic                        ov_q, ov_d;
  logic [IW-1:0]               idx_q, idx_d;
  logic                        last_q, last_d;
  logic signed [OUT_WIDTH-1:0] out_data_q;
  logic signed [ACC_W-1:0]     acc_q [NODE_NUM];
  logic signed [ACC_W-1:0]     acc_d [NODE_NUM];
  logic signed [ACC_W-1:0]     mac_ext [NODE_NUM];
  logic signed [ACC_W-1:0]     bias_ext [NODE_NUM];
  logic signed [ACC_W-1:0]     rq_in;
  logic signed [OUT_WIDTH-1:0] rq_out;

  for (genvar g = 0; g < NODE_NUM; g++) begin : g_neuron
    logic signed [W_WIDTH-1:0] w_s;
    logic signed [W_WIDTH-1:0] b_s;
    logic signed [PW-1:0]      prod_s;
    assign w_s         = w_data[g*W_WIDTH +: W_WIDTH];
    assign b_s         = bias_data[g*W_WIDTH +: W_WIDTH];
    assign prod_s      = x_q * w_s;
    assign mac_ext[g]  = {{(ACC_W-PW){prod_s[PW-1]}}, prod_s};
    // Bias carries only the weight fraction; align it to the product fraction.
    assign bias_ext[g] = {{(ACC_W-W_WIDTH){b_s[W_WIDTH-1]}}, b_s} <<< IN_FRACTION;
  end

  // Next-state, accumulate and emit control.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    pv_d    = 1'b0;
    ov_d    = ov_q;
    idx_d   = idx_q;
    last_d  = last_q;
    for (int n = 0; n < NODE_NUM; n++) begin
      if (pv_q) begin
        acc_d[n] = acc_q[n] + mac_ext[n];
      end else begin
        acc_d[n] = acc_q[n];
      end
    end
    case (state_q)
      ACCUM: begin
        if (in_valid) begin
          x_d  = in_data;
          pv_d = 1'b1;
          if (cnt_q == K_LAST) begin
            state_d = DRAIN;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          x_d = x_q;
        end
      end
      DRAIN: begin
        state_d = BIAS;
      end
      BIAS: begin
        for (int n = 0; n < NODE_NUM; n++) begin
          acc_d[n] = acc_q[n] + bias_ext[n];
        end
        state_d = EMIT;
        ov_d    = 1'b1;
        idx_d   = '0;
        last_d  = (N_LAST == IW'(0));
      end
      EMIT: begin
        if (out_ready && last_q) begin
          for (int n = 0; n < NODE_NUM; n++) begin
            acc_d[n] = '0;
          end
          state_d = ACCUM;
          cnt_d   = '0;
          ov_d    = 1'b0;
          idx_d   = '0;
          last_d  = 1'b0;
        end else if (out_ready) begin
          idx_d  = idx_q + IW'(1);
          last_d = ((idx_q + IW'(1)) == N_LAST);
        end else begin
          idx_d = idx_q;
        end
      end
      default: begin
        state_d = ACCUM;
      end
    endcase
  end

  // The requantiser looks at next-cycle state so out_data is registered.
  assign rq_in = acc_d[idx_d];

  fxp_requant #(
    .IN_W     (ACC_W),
    .IN_FRAC  (IN_FRACTION + W_FRACTION),
    .OUT_W    (OUT_WIDTH),
    .OUT_FRAC (OUT_FRACTION),
    .ACT      (ACT),
    .ROUND    (ROUND)
  ) u_requant (
    .val_i (rq_in),
    .val_o (rq_out)
  );

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ACCUM;
      cnt_q      <= '0;
      x_q        <= '0;
      pv_q       <= 1'b0;
      ov_q       <= 1'b0;
      idx_q      <= '0;
      last_q     <= 1'b0;
      out_data_q <= '0;
      for (int n = 0; n < NODE_NUM; n++) begin
        acc_q[n] <= '0;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      x_q        <= x_d;
      pv_q       <= pv_d;
      ov_q       <= ov_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
      out_data_q <= rq_out;
      for (int n = 0; n < NODE_NUM; n++) begin
        acc_q[n] <= acc_d[n];
      end
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign w_addr    = cnt_q;
  assign out_valid = ov_q;
  assign out_data  = out_data_q;
  assign out_idx   = idx_q;
  assign out_last  = last_q;

endmodule

// File: tb/tb_fc_layer_stream.sv
// Directed bench for fc_layer_stream with two DUTs in lockstep: dut_a uses
// ACT=1/ROUND=1, dut_b uses ACT=0/ROUND=0, so both requant modes are covered.
module tb_fc_layer_stream;

  localparam int NIN = 4;
  localparam int NN  = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [16:0] in_data;
  logic [26:0] w_data;
  logic [26:0] bias_data;
  logic        out_ready;
  logic        in_ready_a, in_ready_b;
  logic [1:0]  w_addr_a, w_addr_b;
  logic        out_valid_a, out_valid_b;
  logic [8:0]  out_data_a, out_data_b;
  logic [1:0]  out_idx_a, out_idx_b;
  logic        out_last_a, out_last_b;

  logic [26:0] w_mem [NIN];
  logic [16:0] xs [NIN];
  logic [8:0]  exp_a [NN];
  logic [8:0]  exp_b [NN];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) w_data <= w_mem[w_addr_a];

  fc_layer_stream #(
    .INPUT_NUM(NIN), .NODE_NUM(NN), .ACT(1), .ROUND(1)
  ) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_data(in_data), .w_addr(w_addr_a), .w_data(w_data),
    .bias_data(bias_data), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_data(out_data_a), .out_idx(out_idx_a), .out_last(out_last_a)
  );

  fc_layer_stream #(
    .INPUT_NUM(NIN), .NODE_NUM(NN), .ACT(0), .ROUND(0)
  ) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_data(in_data), .w_addr(w_addr_b), .w_data(w_data),
    .bias_data(bias_data), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_data(out_data_b), .out_idx(out_idx_b), .out_last(out_last_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_all_weights(input logic [8:0] w);
    for (int r = 0; r < NIN; r++) w_mem[r] = {w, w, w};
  endtask

  task automatic set_expect(input logic [8:0] ea, input logic [8:0] eb);
    for (int n = 0; n < NN; n++) begin
      exp_a[n] = ea;
      exp_b[n] = eb;
    end
  endtask

  // Independent reference: exact integer sum, then ReLU/round/shift/saturate.
  function automatic logic [8:0] model(input int n, input bit act, input bit rnd);
    longint s = 0;
    logic signed [16:0] xv;
    logic signed [8:0]  wv;
    logic signed [8:0]  bv;
    for (int k = 0; k < NIN; k++) begin
      xv = xs[k];
      wv = w_mem[k][n*9 +: 9];
      s += longint'(xv) * longint'(wv);
    end
    bv = bias_data[n*9 +: 9];
    s += longint'(bv) * 64'sd16384;
    if (act && s < 0) s = 0;
    if (rnd) s += 64'sd8192;
    s = s >>> 14;
    if (s > 255) s = 255;
    else if (s < -256) s = -256;
    return s[8:0];
  endfunction

  task automatic send_samples(input int count, input int max_gap);
    int tmo;
    for (int i = 0; i < count; i++) begin
      in_valid = 1'b0;
      repeat ((max_gap > 0) ? $urandom_range(max_gap, 0) : 0) begin
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = xs[i];
      tmo = 0;
      while (!in_ready_a && tmo < 50) begin
        @(posedge clk); #1;
        tmo++;
      end
      chk("in_ready_accept", in_ready_a, 1);
      chk("w_addr_a", w_addr_a, i);
      chk("w_addr_b", w_addr_b, i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_data  = 17'h00000;
  endtask

  task automatic recv_frame(input int stall_idx);
    int lat = 0;
    logic [8:0] hold_a;
    while (!out_valid_a && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("out_valid_first", out_valid_a, 1);
    chk("latency_edges", lat, 2);
    for (int n = 0; n < NN; n++) begin
      chk("out_valid_b", out_valid_b, 1);
      chk("out_data_a", out_data_a, exp_a[n]);
      chk("out_data_b", out_data_b, exp_b[n]);
      chk("out_idx", out_idx_a, n);
      chk("out_last", out_last_a, (n == NN - 1) ? 1 : 0);
      chk("in_ready_emit", in_ready_a, 0);
      if (n == stall_idx) begin
        hold_a    = out_data_a;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 17'h1FFFF;
        repeat (5) begin
          @(posedge clk); #1;
          chk("stall_valid", out_valid_a, 1);
          chk("stall_data", out_data_a, hold_a);
          chk("stall_idx", out_idx_a, n);
          chk("stall_last", out_last_a, 0);
          chk("stall_in_ready", in_ready_a, 0);
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        in_data   = 17'h00000;
      end
      @(posedge clk); #1;
    end
    chk("in_ready_after", in_ready_a, 1);
    chk("in_ready_after_b", in_ready_b, 1);
    chk("out_valid_after", out_valid_a, 0);
    chk("w_addr_after", w_addr_a, 0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 17'h00000;
    out_ready = 1'b1;
    bias_data = 27'h0;
    set_all_weights(9'h000);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid_a, 0);
    chk("rst_in_ready", in_ready_a, 1);
    chk("rst_w_addr", w_addr_a, 0);
    chk("rst_out_idx", out_idx_a, 0);
    chk("rst_out_last", out_last_a, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1.0 x 0.25 summed four times = 1.0
    for (int k = 0; k < NIN; k++) xs[k] = 17'h04000;
    set_all_weights(9'h020);
    set_expect(9'h080, 9'h080);
    send_samples(NIN, 0);
    recv_frame(-1);

    // sum 4.0 saturates high
    set_all_weights(9'h080);
    set_expect(9'h0FF, 9'h0FF);
    send_samples(NIN, 0);
    recv_frame(-1);

    // sum -4.0: ReLU gives 0, otherwise saturates low
    set_all_weights(9'h180);
    set_expect(9'h000, 9'h100);
    send_samples(NIN, 0);
    recv_frame(-1);

    // half output LSB: rounds up to 1, truncates to 0
    xs[0] = 17'h00040;
    for (int k = 1; k < NIN; k++) xs[k] = 17'h00000;
    set_all_weights(9'h080);
    set_expect(9'h001, 9'h000);
    send_samples(NIN, 0);
    recv_frame(-1);

    // bias 0.5 adds 0x040
    bias_data = {9'h040, 9'h040, 9'h040};
    set_expect(9'h041, 9'h040);
    send_samples(NIN, 0);
    recv_frame(-1);
    bias_data = 27'h0;

    // output back-pressure at idx 1
    for (int k = 0; k < NIN; k++) xs[k] = 17'h04000;
    set_all_weights(9'h020);
    set_expect(9'h080, 9'h080);
    send_samples(NIN, 0);
    recv_frame(1);

    // reset after two samples, then a clean frame
    xs[0] = 17'h1C000;
    xs[1] = 17'h0C000;
    send_samples(2, 0);
    rst = 1'b1;
    #2;
    chk("midrst_in_ready", in_ready_a, 1);
    chk("midrst_w_addr", w_addr_a, 0);
    chk("midrst_out_valid", out_valid_a, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < NIN; k++) xs[k] = 17'h04000;
    send_samples(NIN, 0);
    recv_frame(-1);

    // back-to-back random frames with random input gaps
    for (int f = 0; f < 4; f++) begin
      for (int k = 0; k < NIN; k++) begin
        xs[k] = 17'($urandom_range(16383, 0)) - 17'd8192;
        for (int n = 0; n < NN; n++) w_mem[k][n*9 +: 9] = 9'($urandom_range(511, 0));
      end
      for (int n = 0; n < NN; n++) bias_data[n*9 +: 9] = 9'($urandom_range(127, 0)) - 9'd64;
      for (int n = 0; n < NN; n++) begin
        exp_a[n] = model(n, 1'b1, 1'b1);
        exp_b[n] = model(n, 1'b0, 1'b0);
      end
      send_samples(NIN, 3);
      recv_frame(-1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
